// File: rtl/boton_pulso_if.sv
// rtl/boton_pulso_if.sv - button pin in, move strobe and debounced level out
interface boton_pulso_if;
  logic boton_in;
  logic move;
  logic pressed;

  modport master (output boton_in, input move, input pressed);
  modport slave  (input boton_in, output move, output pressed);
endinterface

// File: rtl/boton_pulso.sv
// rtl/boton_pulso.sv - debounced push-button to one-cycle move strobe (optional auto-repeat: BOTON_AUTOREPEAT_EN)
module boton_pulso #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CNT_W           = 25
) (
  input  logic          clk,
  input  logic          rst,
  boton_pulso_if.slave  bus
);

  // Pin level that means "not pressed"; the synchronizer starts there so reset looks like a release.
  localparam logic REL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM_P, PRESSED, ARM_R} state_t;

  logic sync1, sync2, s;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic move_q, move_nx;
  logic pressed_q, pressed_nx;

`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt, rcnt_nx;
  logic rep_on, rep_on_nx;
  logic rep_hit;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= bus.boton_in;
      sync2 <= sync1;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      move_q    <= 1'b0;
      pressed_q <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
      rcnt      <= '0;
      rep_on    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      move_q    <= move_nx;
      pressed_q <= pressed_nx;
`ifdef BOTON_AUTOREPEAT_EN
      rcnt      <= rcnt_nx;
      rep_on    <= rep_on_nx;
`endif
    end
  end

  // Next state: a level change is accepted only after DEBOUNCE_CYCLES agreeing samples.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    move_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = ARM_P;
          cnt_nx   = '0;
        end
      end
      ARM_P: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          move_nx  = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nx = ARM_R;
          cnt_nx   = '0;
        end
      end
      ARM_R: begin
        if (s) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

`ifdef BOTON_AUTOREPEAT_EN
    // Repeat timer: runs only while settled in PRESSED, holds through ARM_R, restarts per new press.
    rcnt_nx   = rcnt;
    rep_on_nx = rep_on;
    rep_hit   = rep_on ? (rcnt == RP_LAST) : (rcnt == RD_LAST);
    if (state == ARM_P && state_nx == PRESSED) begin
      rcnt_nx   = '0;
      rep_on_nx = 1'b0;
    end else if (state_nx == IDLE) begin
      rcnt_nx   = '0;
      rep_on_nx = 1'b0;
    end else if (state == PRESSED && state_nx == PRESSED) begin
      if (rep_hit) begin
        // A strobe the cycle before delays this one by a cycle so move never stays high.
        if (!move_q) begin
          move_nx   = 1'b1;
          rcnt_nx   = '0;
          rep_on_nx = 1'b1;
        end
      end else if (rcnt != CNT_MAX) begin
        rcnt_nx = rcnt + 1'b1;
      end
    end
`endif

    pressed_nx = (state_nx == PRESSED) || (state_nx == ARM_R);
  end

  assign bus.move    = move_q;
  assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_boton_pulso.sv
// tb/tb_boton_pulso.sv - self-checking bench for boton_pulso (BOTON_AUTOREPEAT_EN selects repeat checks)
module tb_boton_pulso;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BOTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic boton;
    int   cycles;
    int   exp_moves;
    logic exp_pressed;
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  boton_pulso_if bif ();

  boton_pulso #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int moves_seen = 0;

  // Reference model: run-length debounce of the 2-edge-delayed pressed level.
  logic raw_q[$];
  logic level;
  int   run;
  int   hold;
  logic exp_move;
  logic exp_pressed;

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    level = 1'b0; run = 0; hold = 0;
    exp_move = 1'b0; exp_pressed = 1'b0;
  endtask

  task automatic model_edge(input logic raw);
    logic sv;
    int prev_run;
    sv = raw_q[0];
    raw_q.push_back(raw);
    void'(raw_q.pop_front());
    exp_move = 1'b0;
    prev_run = run;
    run = (sv != level) ? run + 1 : 0;
    if (run == D + 1) begin
      level = sv;
      run = 0;
      if (level) begin
        exp_move = 1'b1;
        hold = 0;
      end
    end else if (AR && level && prev_run == 0 && sv) begin
      hold++;
      if (hold == RD || (hold > RD && (hold - RD) % RP == 0)) exp_move = 1'b1;
    end
    exp_pressed = level;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(bif.boton_in == 1'b0);
    #1;
    check_bit("move", bif.move, exp_move);
    check_bit("pressed", bif.pressed, exp_pressed);
    if (bif.move === 1'b1) moves_seen++;
  endtask

  function automatic int mv(input int n);
    return AR ? -1 : n;
  endfunction

  seg_t tbl[$];

  initial begin
    int first, fall, cnt, m0;
    int offs[$];
    int exp_offs[$];

    tbl.push_back('{1'b1, 50, 0, 1'b0});
    tbl.push_back('{1'b0, 30, mv(1), 1'b1});
    tbl.push_back('{1'b1, 30, mv(0), 1'b0});
    for (int k = 0; k < 5; k++) begin
      tbl.push_back('{1'b0, 2, 0, 1'b0});
      tbl.push_back('{1'b1, 2, 0, 1'b0});
    end
    tbl.push_back('{1'b1, 10, 0, 1'b0});
    tbl.push_back('{1'b0, 20, mv(1), 1'b1});
    tbl.push_back('{1'b1, 2, mv(0), 1'b1});
    tbl.push_back('{1'b0, 10, mv(0), 1'b1});
    tbl.push_back('{1'b1, 15, mv(0), 1'b0});

    // Reset pulse mid-cycle; outputs must clear without a clock edge.
    bif.boton_in = 1'b1;
    #12 rst = 1'b1;
    model_reset();
    #1;
    check_bit("async_rst_move", bif.move, 1'b0);
    check_bit("async_rst_pressed", bif.pressed, 1'b0);
    tick();
    tick();
    #2 rst = 1'b0;

    // Table-driven segments.
    foreach (tbl[j]) begin
      bif.boton_in = tbl[j].boton;
      m0 = moves_seen;
      for (int c = 0; c < tbl[j].cycles; c++) tick();
      if (tbl[j].exp_moves >= 0) check_int("seg_moves", moves_seen - m0, tbl[j].exp_moves);
      check_bit("seg_pressed", bif.pressed, tbl[j].exp_pressed);
    end

    // Press latency: strobe and pressed both appear after edge E0+D+2.
    bif.boton_in = 1'b0;
    first = -1; fall = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bif.move === 1'b1 && first < 0) first = i;
      if (bif.pressed === 1'b1 && fall < 0) fall = i;
    end
    check_int("press_latency", first, D + 2);
    check_int("pressed_rise", fall, D + 2);

    // Release latency.
    bif.boton_in = 1'b1;
    fall = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bif.pressed === 1'b0 && fall < 0) fall = i;
    end
    check_int("release_latency", fall, D + 2);

    // Reset during ARM_P discards the pending strobe; a still-held button re-debounces.
    bif.boton_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_bit("mid_rst_move", bif.move, 1'b0);
    check_bit("mid_rst_pressed", bif.pressed, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b0;
    first = -1; cnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (bif.move === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check_int("rst_press_latency", first, D + 2);
    check_int("rst_press_count", cnt, 1);
    bif.boton_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();

`ifdef BOTON_AUTOREPEAT_EN
    // Auto-repeat cadence relative to the first strobe, then silence after release.
    bif.boton_in = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      tick();
      if (bif.move === 1'b1) offs.push_back(i);
    end
    exp_offs = '{6, 26, 34, 42, 50, 58};
    check_int("repeat_count", offs.size(), exp_offs.size());
    foreach (exp_offs[k]) check_int("repeat_offset", (k < offs.size()) ? offs[k] : -1, exp_offs[k]);
    bif.boton_in = 1'b1;
    m0 = moves_seen;
    for (int i = 0; i < 30; i++) tick();
    check_int("repeat_after_release", moves_seen - m0, 0);
`endif

    // Randomized segments against the model.
    for (int k = 0; k < 120; k++) begin
      bif.boton_in = 1'($urandom_range(0, 1));
      cnt = $urandom_range(1, 9);
      for (int c = 0; c < cnt; c++) tick();
    end
    bif.boton_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_bit("final_pressed", bif.pressed, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
